// File: rtl/axi_bridge_if.sv
// rtl/axi_bridge_if.sv - request/response and AXI4 master signal bundle for axi_bridge
//
// Groups the CPU-side request/response handshake and the id-less AXI4 master
// channels (AW, W, B, AR, R). Modport master is the bridge view; modport slave
// is the view of whatever sits around it (requester plus AXI slave).
// Parameters: ADDR_WIDTH (32/64), DATA_WIDTH (32/64/128), STRB_WIDTH derived.

interface axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // request / response
    logic                  req_valid;
    logic                  req_instr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_wstrb;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    // write address
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic [3:0]            m_axi_awqos;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    // write data
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    // write response
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    // read address
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic [3:0]            m_axi_arqos;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    // read data
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
               m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
               m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
               m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
               m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_bridge.sv
// rtl/axi_bridge.sv - single-beat request to AXI4 master bridge
//
// Ports: clock (rising edge), reset (synchronous, active-low),
//        bus (axi_bridge_if.master: request/response + AXI4 AW/W/B/AR/R).
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (watchdog limit in cycles).
// Optional feature: define AXI_BRIDGE_TIMEOUT_EN to abort a READ/WRITE that
// waits TIMEOUT cycles, answering with resp_error=1.

module axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clock,
    input  logic              reset,
    axi_bridge_if.master      bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [2:0]            prot_q;
    logic                  ar_pending, aw_pending, w_pending;
    logic                  resp_valid_q, resp_error_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic req_ready_c, arvalid_c, rready_c, awvalid_c, wvalid_c, bready_c;
    logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, timeout_hit;

    // Bus-level rlast and the low response bits carry no information for single beats.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.m_axi_rlast, bus.m_axi_rresp[0], bus.m_axi_bresp[0]};

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- output decode ----------------
    always_comb begin
        req_ready_c = (state == IDLE);
        arvalid_c   = (state == READ)  && ar_pending;
        rready_c    = (state == READ);
        awvalid_c   = (state == WRITE) && aw_pending;
        wvalid_c    = (state == WRITE) && w_pending;
        // B is only accepted once both address and data have been handed over,
        // so an early bvalid from a misbehaving slave is simply left waiting.
        bready_c    = (state == WRITE) && !aw_pending && !w_pending;
    end

    assign accept = bus.req_valid && req_ready_c;
    assign ar_hs  = arvalid_c && bus.m_axi_arready;
    assign r_hs   = rready_c  && bus.m_axi_rvalid;
    assign aw_hs  = awvalid_c && bus.m_axi_awready;
    assign w_hs   = wvalid_c  && bus.m_axi_wready;
    assign b_hs   = bready_c  && bus.m_axi_bvalid;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    // Counts busy cycles; the last allowed cycle is TIMEOUT-1 so the abort
    // lands after exactly TIMEOUT READ/WRITE cycles.
    always_ff @(posedge clock) begin
        if (!reset)               tmo_cnt <= 16'd0;
        else if (accept)          tmo_cnt <= 16'd0;
        else if (state != IDLE)   tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign timeout_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (bus.req_wstrb == '0) ? READ : WRITE;
            READ:    if (r_hs || timeout_hit) state_next = IDLE;
            WRITE:   if (b_hs || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath / response ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            prot_q       <= 3'b000;
            ar_pending   <= 1'b0;
            aw_pending   <= 1'b0;
            w_pending    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            // Response is a single-cycle pulse; data and error are zero otherwise.
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= bus.req_addr & ADDR_MASK;
                        wdata_q    <= bus.req_wdata;
                        wstrb_q    <= bus.req_wstrb;
                        prot_q     <= {bus.req_instr, 2'b00};
                        ar_pending <= (bus.req_wstrb == '0);
                        aw_pending <= (bus.req_wstrb != '0);
                        w_pending  <= (bus.req_wstrb != '0);
                    end
                end
                READ: begin
                    if (ar_hs) ar_pending <= 1'b0;
                    if (r_hs) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= bus.m_axi_rdata;
                        resp_error_q <= bus.m_axi_rresp[1];
                    end else if (timeout_hit) begin
                        ar_pending   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (aw_hs) aw_pending <= 1'b0;
                    if (w_hs)  w_pending  <= 1'b0;
                    if (b_hs) begin
                        resp_valid_q <= 1'b1;
                        resp_error_q <= bus.m_axi_bresp[1];
                    end else if (timeout_hit) begin
                        aw_pending   <= 1'b0;
                        w_pending    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- bus drive ----------------
    assign bus.req_ready     = req_ready_c;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_error    = resp_error_q;

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = 8'd0;
    assign bus.m_axi_awsize  = 3'(SIZE);
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'b0000;
    assign bus.m_axi_awprot  = prot_q;
    assign bus.m_axi_awqos   = 4'b0000;
    assign bus.m_axi_awvalid = awvalid_c;

    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wlast   = 1'b1;
    assign bus.m_axi_wvalid  = wvalid_c;

    assign bus.m_axi_bready  = bready_c;

    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = 8'd0;
    assign bus.m_axi_arsize  = 3'(SIZE);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0000;
    assign bus.m_axi_arprot  = prot_q;
    assign bus.m_axi_arqos   = 4'b0000;
    assign bus.m_axi_arvalid = arvalid_c;

    assign bus.m_axi_rready  = rready_c;
endmodule

// File: tb/tb_axi_bridge.sv
// tb/tb_axi_bridge.sv - directed self-checking bench for axi_bridge

module tb_axi_bridge;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rdata   = 32'h0;
        bus.m_axi_rlast   = 1'b1;
    endtask

    task automatic request(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic instr);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wstrb = strb;
        bus.req_instr = instr;
    endtask

    initial begin
        int  cycles;
        int  ar_drops;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        bus.req_instr = 1'b0;
        slave_idle();

        // ---- reset state ----
        tick();
        tick();
        check("rst_req_ready",  32'(bus.req_ready),     32'd1);
        check("rst_arvalid",    32'(bus.m_axi_arvalid), 32'd0);
        check("rst_awvalid",    32'(bus.m_axi_awvalid), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid),    32'd0);
        check("rst_araddr",     bus.m_axi_araddr,       32'h0);
        reset = 1'b1;
        tick();

        // ---- load 0x1003, slave answers at N+1 ----
        request(32'h1003, 32'h0, 4'h0, 1'b0);
        tick();                                  // N+1
        bus.req_valid = 1'b0;
        check("ld_arvalid",   32'(bus.m_axi_arvalid), 32'd1);
        check("ld_rready",    32'(bus.m_axi_rready),  32'd1);
        check("ld_araddr",    bus.m_axi_araddr,       32'h1000);
        check("ld_arsize",    32'(bus.m_axi_arsize),  32'd2);
        check("ld_arburst",   32'(bus.m_axi_arburst), 32'd1);
        check("ld_arprot",    32'(bus.m_axi_arprot),  32'd0);
        check("ld_req_ready", 32'(bus.req_ready),     32'd0);
        check("ld_resp_idle", 32'(bus.resp_valid),    32'd0);
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rvalid  = 1'b1;
        bus.m_axi_rdata   = 32'hCAFEF00D;
        tick();                                  // N+2
        slave_idle();
        check("ld_resp_valid", 32'(bus.resp_valid),    32'd1);
        check("ld_resp_rdata", bus.resp_rdata,         32'hCAFEF00D);
        check("ld_resp_error", 32'(bus.resp_error),    32'd0);
        check("ld_arvalid_off",32'(bus.m_axi_arvalid), 32'd0);
        check("ld_b2b_ready",  32'(bus.req_ready),     32'd1);

        // ---- back-to-back store: wready N+1, awready N+4, bvalid N+5 ----
        request(32'h2000, 32'hA5A5A5A5, 4'hF, 1'b0);
        tick();                                  // N+1
        bus.req_valid = 1'b0;
        check("st_resp_clear", 32'(bus.resp_valid),    32'd0);
        check("st_rdata_zero", bus.resp_rdata,         32'h0);
        check("st_awvalid1",   32'(bus.m_axi_awvalid), 32'd1);
        check("st_wvalid1",    32'(bus.m_axi_wvalid),  32'd1);
        check("st_wdata",      bus.m_axi_wdata,        32'hA5A5A5A5);
        check("st_wstrb",      32'(bus.m_axi_wstrb),   32'hF);
        check("st_wlast",      32'(bus.m_axi_wlast),   32'd1);
        bus.m_axi_wready = 1'b1;
        tick();                                  // N+2
        bus.m_axi_wready = 1'b0;
        check("st_wvalid_drop", 32'(bus.m_axi_wvalid),  32'd0);
        check("st_awvalid2",    32'(bus.m_axi_awvalid), 32'd1);
        check("st_bready_wait", 32'(bus.m_axi_bready),  32'd0);
        tick();                                  // N+3
        check("st_awvalid3",    32'(bus.m_axi_awvalid), 32'd1);
        tick();                                  // N+4
        check("st_awvalid4",    32'(bus.m_axi_awvalid), 32'd1);
        check("st_awaddr",      bus.m_axi_awaddr,       32'h2000);
        bus.m_axi_awready = 1'b1;
        tick();                                  // N+5
        bus.m_axi_awready = 1'b0;
        check("st_awvalid_drop", 32'(bus.m_axi_awvalid), 32'd0);
        check("st_bready",       32'(bus.m_axi_bready),  32'd1);
        check("st_resp_early",   32'(bus.resp_valid),    32'd0);
        bus.m_axi_bvalid = 1'b1;
        tick();                                  // N+6
        slave_idle();
        check("st_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("st_resp_error", 32'(bus.resp_error), 32'd0);
        check("st_resp_rdata", bus.resp_rdata,      32'h0);
        tick();
        check("st_resp_pulse", 32'(bus.resp_valid), 32'd0);

        // ---- store, early bvalid ignored, bresp SLVERR ----
        request(32'h4008, 32'h11223344, 4'h3, 1'b0);
        tick();                                  // N+1
        bus.req_valid = 1'b0;
        bus.m_axi_awready = 1'b1;
        bus.m_axi_wready  = 1'b1;
        bus.m_axi_bvalid  = 1'b1;
        bus.m_axi_bresp   = 2'b10;
        check("err_bready_early", 32'(bus.m_axi_bready), 32'd0);
        tick();                                  // N+2
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        check("err_b_ignored", 32'(bus.resp_valid),   32'd0);
        check("err_bready",    32'(bus.m_axi_bready), 32'd1);
        tick();                                  // N+3
        slave_idle();
        check("err_st_valid", 32'(bus.resp_valid), 32'd1);
        check("err_st_error", 32'(bus.resp_error), 32'd1);

        // ---- instruction load with DECERR ----
        request(32'h3007, 32'h0, 4'h0, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        check("ild_araddr", bus.m_axi_araddr,      32'h3004);
        check("ild_arprot", 32'(bus.m_axi_arprot), 32'h4);
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rvalid  = 1'b1;
        bus.m_axi_rdata   = 32'h12345678;
        bus.m_axi_rresp   = 2'b11;
        tick();
        slave_idle();
        check("ild_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("ild_resp_error", 32'(bus.resp_error), 32'd1);
        check("ild_resp_rdata", bus.resp_rdata,      32'h12345678);

        // ---- reset during pending read ----
        request(32'h5000, 32'h0, 4'h0, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        check("mr_arvalid", 32'(bus.m_axi_arvalid), 32'd1);
        reset = 1'b0;
        tick();
        check("mr_arvalid_rst", 32'(bus.m_axi_arvalid), 32'd0);
        check("mr_rready_rst",  32'(bus.m_axi_rready),  32'd0);
        check("mr_resp_rst",    32'(bus.resp_valid),    32'd0);
        reset = 1'b1;
        tick();
        check("mr_req_ready", 32'(bus.req_ready),     32'd1);
        check("mr_resp_post", 32'(bus.resp_valid),    32'd0);
        check("mr_ar_post",   32'(bus.m_axi_arvalid), 32'd0);

        // ---- silent slave ----
        request(32'h6000, 32'h0, 4'h0, 1'b0);
        tick();                                  // first READ cycle
        bus.req_valid = 1'b0;
        cycles = 1;
`ifdef AXI_BRIDGE_TIMEOUT_EN
        while (!bus.resp_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check("tmo_latency",    32'(cycles),            32'd17);
        check("tmo_resp_valid", 32'(bus.resp_valid),    32'd1);
        check("tmo_resp_error", 32'(bus.resp_error),    32'd1);
        check("tmo_resp_rdata", bus.resp_rdata,         32'h0);
        check("tmo_arvalid",    32'(bus.m_axi_arvalid), 32'd0);
        check("tmo_req_ready",  32'(bus.req_ready),     32'd1);
`else
        ar_drops = 0;
        while (cycles < 120) begin
            if (!bus.m_axi_arvalid || bus.resp_valid) ar_drops++;
            tick();
            cycles++;
        end
        check("hang_ar_held",   32'(ar_drops),          32'd0);
        check("hang_arvalid",   32'(bus.m_axi_arvalid), 32'd1);
        check("hang_req_ready", 32'(bus.req_ready),     32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
